// File: rtl/beam_pkg.sv
// Shared definitions for the beam transmit sequencer: FSM encoding and default widths.
package beam_pkg;

    localparam int DEF_NUM_CH  = 32'd8;
    localparam int DEF_CNT_W   = 32'd12;
    localparam int DEF_DIV_W   = 32'd8;
    localparam int DEF_BURST_W = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/beam_tick_gen.sv
// Tick prescaler: one tick every div_ratio+1 enabled clocks, counter held at zero while disabled.
module beam_tick_gen
    import beam_pkg::*;
#(
    parameter int DIV_W = DEF_DIV_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             en,
    input  logic [DIV_W-1:0] div_ratio,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_r;

    assign tick = en && (cnt_r == div_ratio);

    // Prescale counter; clearing while disabled makes every burst start from count 0.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (!en) begin
            cnt_r <= '0;
        end else if (tick) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + DIV_W'(1);
        end
    end

endmodule

// File: rtl/beam_tx_sequencer.sv
// Multi-channel ultrasound transmit pulse sequencer: shadowed burst configuration,
// prescaled tick counter and per-channel pos/neg window compare driving the pulser pins.
module beam_tx_sequencer
    import beam_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int DIV_W   = DEF_DIV_W,
    parameter int BURST_W = DEF_BURST_W
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic [DIV_W-1:0]        div_ratio,
    input  logic [CNT_W-1:0]        period,
    input  logic [CNT_W-1:0]        on_time,
    input  logic [NUM_CH*CNT_W-1:0] delay_flat,
    input  logic [NUM_CH-1:0]       ch_mask,
    input  logic                    bipolar,
    input  logic [BURST_W-1:0]      burst_len,
    output logic [NUM_CH-1:0]       pos_out,
    output logic [NUM_CH-1:0]       neg_out,
    output logic                    busy,
    output logic                    done
);

    // Two guard bits so delay + 2*on_time never wraps in the window compare.
    localparam int CMP_W = CNT_W + 2;

    state_t state_r;
    state_t state_s;

    logic [DIV_W-1:0]        div_r;
    logic [CNT_W-1:0]        period_r;
    logic [CNT_W-1:0]        on_time_r;
    logic [NUM_CH*CNT_W-1:0] delay_r;
    logic [NUM_CH-1:0]       mask_r;
    logic                    bipolar_r;
    logic [BURST_W-1:0]      burst_r;

    logic [CNT_W-1:0]   tick_cnt_r;
    logic [BURST_W-1:0] burst_cnt_r;

    logic [NUM_CH-1:0] pos_r;
    logic [NUM_CH-1:0] neg_r;
    logic              busy_r;
    logic              done_r;

    logic              run_s;
    logic              tick_s;
    logic              wrap_s;
    logic              last_s;
    logic              capture_s;
    logic [NUM_CH-1:0] pos_s;
    logic [NUM_CH-1:0] neg_s;

    assign run_s  = (state_r == ST_RUN);
    assign wrap_s = tick_s && (tick_cnt_r == (period_r - CNT_W'(1)));
    assign last_s = wrap_s && (burst_cnt_r == (burst_r - BURST_W'(1)));

    beam_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (run_s),
        .div_ratio (div_r),
        .tick      (tick_s)
    );

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stop outranks both start and normal burst completion.
    always_comb begin
        state_s   = state_r;
        capture_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    capture_s = 1'b1;
                    if (period == '0) begin
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_s = ST_IDLE;
                end else if (last_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Shadow copy of the configuration, frozen for the whole burst.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            div_r     <= '0;
            period_r  <= '0;
            on_time_r <= '0;
            delay_r   <= '0;
            mask_r    <= '0;
            bipolar_r <= 1'b0;
            burst_r   <= '0;
        end else if (capture_s) begin
            div_r     <= div_ratio;
            period_r  <= period;
            on_time_r <= on_time;
            delay_r   <= delay_flat;
            mask_r    <= ch_mask;
            bipolar_r <= bipolar;
            burst_r   <= (burst_len == '0) ? BURST_W'(1) : burst_len;
        end else begin
            div_r     <= div_r;
            period_r  <= period_r;
            on_time_r <= on_time_r;
            delay_r   <= delay_r;
            mask_r    <= mask_r;
            bipolar_r <= bipolar_r;
            burst_r   <= burst_r;
        end
    end

    // Tick position within the period and number of completed periods.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tick_cnt_r  <= '0;
            burst_cnt_r <= '0;
        end else if (capture_s) begin
            tick_cnt_r  <= '0;
            burst_cnt_r <= '0;
        end else if (run_s && tick_s) begin
            if (wrap_s) begin
                tick_cnt_r  <= '0;
                burst_cnt_r <= burst_cnt_r + BURST_W'(1);
            end else begin
                tick_cnt_r  <= tick_cnt_r + CNT_W'(1);
                burst_cnt_r <= burst_cnt_r;
            end
        end else begin
            tick_cnt_r  <= tick_cnt_r;
            burst_cnt_r <= burst_cnt_r;
        end
    end

    // Per-channel firing windows: pos in [d, d+w), neg in [d+w, d+2w); disjoint by construction.
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CMP_W-1:0] d_s;
        logic [CMP_W-1:0] w_s;
        logic [CMP_W-1:0] t_s;

        assign d_s = {2'b00, delay_r[i*CNT_W +: CNT_W]};
        assign w_s = {2'b00, on_time_r};
        assign t_s = {2'b00, tick_cnt_r};

        assign pos_s[i] = mask_r[i] && (t_s >= d_s) && (t_s < (d_s + w_s));
        assign neg_s[i] = mask_r[i] && bipolar_r
                          && (t_s >= (d_s + w_s)) && (t_s < (d_s + w_s + w_s));
    end

    // Registered pin drive; anything other than a RUN->RUN step forces the pulsers off.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pos_r  <= '0;
            neg_r  <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            if (run_s && (state_s == ST_RUN)) begin
                pos_r <= pos_s;
                neg_r <= neg_s;
            end else begin
                pos_r <= '0;
                neg_r <= '0;
            end
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

    assign pos_out = pos_r;
    assign neg_out = neg_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_beam_tx_sequencer.sv
// Self-checking bench for beam_tx_sequencer: directed table, hand-written corner sequences
// and randomized bursts against a cycle-index reference model of the burst waveform.
module tb_beam_tx_sequencer;

    localparam int NUM_CH  = 8;
    localparam int CNT_W   = 12;
    localparam int DIV_W   = 8;
    localparam int BURST_W = 4;

    logic                    clock;
    logic                    reset_n;
    logic                    start;
    logic                    stop;
    logic [DIV_W-1:0]        div_ratio;
    logic [CNT_W-1:0]        period;
    logic [CNT_W-1:0]        on_time;
    logic [NUM_CH*CNT_W-1:0] delay_flat;
    logic [NUM_CH-1:0]       ch_mask;
    logic                    bipolar;
    logic [BURST_W-1:0]      burst_len;
    logic [NUM_CH-1:0]       pos_out;
    logic [NUM_CH-1:0]       neg_out;
    logic                    busy;
    logic                    done;

    int checks;
    int failures;

    typedef struct {
        logic [7:0]  div;
        logic [11:0] period;
        logic [11:0] on;
        logic [95:0] delay;
        logic [7:0]  mask;
        logic        bip;
        logic [3:0]  burst;
    } cfg_t;

    typedef struct {
        cfg_t c;
        bit   scramble;
        bit   start_in_done;
        int   exp_busy;
        int   exp_done;
        int   exp_pos;
        int   exp_neg;
    } vec_t;

    beam_tx_sequencer dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .stop       (stop),
        .div_ratio  (div_ratio),
        .period     (period),
        .on_time    (on_time),
        .delay_flat (delay_flat),
        .ch_mask    (ch_mask),
        .bipolar    (bipolar),
        .burst_len  (burst_len),
        .pos_out    (pos_out),
        .neg_out    (neg_out),
        .busy       (busy),
        .done       (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s k=%0d actual=%h expected=%h", name, k, act, exp);
        end
    endtask

    function automatic logic [95:0] fill_delay(input int v);
        logic [95:0] d;
        for (int i = 0; i < NUM_CH; i++) d[i*CNT_W +: CNT_W] = CNT_W'(v);
        return d;
    endfunction

    function automatic cfg_t mk(input int dv, input int per, input int on, input logic [95:0] dl,
                                input int mask, input bit bip, input int bl);
        cfg_t c;
        c.div = 8'(dv); c.period = 12'(per); c.on = 12'(on); c.delay = dl;
        c.mask = 8'(mask); c.bip = bip; c.burst = 4'(bl);
        return c;
    endfunction

    function automatic cfg_t rand_cfg();
        logic [95:0] dl;
        int per;
        for (int i = 0; i < NUM_CH; i++) dl[i*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 20));
        per = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 20));
        return mk($urandom_range(0, 3), per, $urandom_range(0, 8), dl,
                  $urandom_range(0, 255), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    endfunction

    // Number of clocks the burst spends busy.
    function automatic int run_len(input cfg_t c);
        int bl;
        bl = (c.burst == 4'd0) ? 1 : int'(c.burst);
        if (c.period == 12'd0) return 0;
        return bl * int'(c.period) * (int'(c.div) + 1);
    endfunction

    // Expected outputs in cycle k after the start edge (k=1 is the first cycle after it).
    function automatic void expect_at(input cfg_t c, input int k, input int stop_k,
                                      output logic [7:0] ep, output logic [7:0] en,
                                      output logic eb, output logic ed);
        int len, t, d, w;
        ep = 8'd0; en = 8'd0; eb = 1'b0; ed = 1'b0;
        len = run_len(c);
        if (c.period == 12'd0) begin
            ed = (k == 1);
            return;
        end
        if (stop_k > 0 && k > stop_k) return;
        eb = (k >= 1 && k <= len);
        ed = (k == len + 1);
        if (k >= 2 && k <= len) begin
            t = ((k - 2) / (int'(c.div) + 1)) % int'(c.period);
            w = int'(c.on);
            for (int i = 0; i < NUM_CH; i++) begin
                d = int'(c.delay[i*CNT_W +: CNT_W]);
                ep[i] = c.mask[i] && (t >= d) && (t < d + w);
                en[i] = c.mask[i] && c.bip && (t >= d + w) && (t < d + 2 * w);
            end
        end
    endfunction

    task automatic apply_cfg(input cfg_t c);
        div_ratio = c.div; period = c.period; on_time = c.on; delay_flat = c.delay;
        ch_mask = c.mask; bipolar = c.bip; burst_len = c.burst;
    endtask

    // Starts one burst (inputs driven just after a falling edge) and checks every cycle.
    task automatic run_burst(input cfg_t c, input int stop_k, input bit scramble, input bit start_in_done,
                             input bit rnd_start, output int busy_n, output int done_n,
                             output int pos_n, output int neg_n, output int both_n);
        int len, last_k;
        logic [7:0] ep, en;
        logic eb, ed;
        len = run_len(c);
        last_k = (stop_k > 0) ? stop_k + 3 : len + 3;
        busy_n = 0; done_n = 0; pos_n = 0; neg_n = 0; both_n = 0;
        apply_cfg(c);
        stop = 1'b0;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        for (int k = 1; k <= last_k; k++) begin
            expect_at(c, k, stop_k, ep, en, eb, ed);
            check("wave", k, {14'd0, pos_out, neg_out, busy, done}, {14'd0, ep, en, eb, ed});
            busy_n += int'(busy);
            done_n += int'(done);
            pos_n  += $countones(pos_out);
            neg_n  += $countones(neg_out);
            both_n += $countones(pos_out & neg_out);
            if (scramble) apply_cfg(rand_cfg());
            stop  = (k == stop_k);
            start = 1'b0;
            if (start_in_done && k == len + 1) begin
                start = 1'b1;
            end else if (rnd_start && k <= len && (stop_k <= 0 || k < stop_k)
                         && $urandom_range(0, 7) == 0) begin
                start = 1'b1;
            end
            @(negedge clock);
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        vec_t tbl[6];
        logic [95:0] dl;
        int b_n, d_n, p_n, n_n, x_n;

        checks = 0; failures = 0;
        reset_n = 1'b0; start = 1'b0; stop = 1'b0;
        apply_cfg(mk(0, 0, 0, 96'd0, 0, 1'b0, 0));

        @(negedge clock);
        check("reset_state", 0, {14'd0, pos_out, neg_out, busy, done}, 32'd0);
        reset_n = 1'b1;
        @(negedge clock);

        for (int i = 0; i < NUM_CH; i++) dl[i*CNT_W +: CNT_W] = CNT_W'(i);
        tbl[0] = '{mk(0, 10, 2, dl, 8'hFF, 1'b0, 1), 1'b0, 1'b0, 10, 1, 16, 0};
        tbl[1] = '{mk(0, 10, 3, fill_delay(0), 8'hFF, 1'b1, 1), 1'b1, 1'b0, 10, 1, 24, 24};
        tbl[2] = '{mk(3, 5, 1, fill_delay(0), 8'h01, 1'b0, 3), 1'b0, 1'b1, 60, 1, 12, 0};
        dl = fill_delay(100);
        dl[0 +: CNT_W]  = 12'd0;
        dl[84 +: CNT_W] = 12'd235;
        tbl[3] = '{mk(0, 300, 10, dl, 8'h81, 1'b0, 1), 1'b0, 1'b0, 300, 1, 20, 0};
        tbl[4] = '{mk(0, 0, 3, fill_delay(0), 8'hFF, 1'b1, 2), 1'b0, 1'b1, 0, 1, 0, 0};
        tbl[5] = '{mk(1, 4, 2, fill_delay(0), 8'h01, 1'b1, 0), 1'b0, 1'b0, 8, 1, 4, 3};

        for (int v = 0; v < 6; v++) begin
            run_burst(tbl[v].c, -1, tbl[v].scramble, tbl[v].start_in_done, 1'b0, b_n, d_n, p_n, n_n, x_n);
            check("tbl_busy_cycles", v, b_n, tbl[v].exp_busy);
            check("tbl_done_pulses", v, d_n, tbl[v].exp_done);
            check("tbl_pos_count", v, p_n, tbl[v].exp_pos);
            check("tbl_neg_count", v, n_n, tbl[v].exp_neg);
            check("tbl_pos_neg_overlap", v, x_n, 0);
        end

        // Stop at tick 4 (cycle 5), then a fresh start replays from tick 0.
        for (int i = 0; i < NUM_CH; i++) dl[i*CNT_W +: CNT_W] = CNT_W'(i);
        run_burst(mk(0, 10, 2, dl, 8'hFF, 1'b0, 1), 5, 1'b0, 1'b0, 1'b0, b_n, d_n, p_n, n_n, x_n);
        check("stop_no_done", 0, d_n, 0);
        check("stop_busy_cycles", 0, b_n, 5);
        run_burst(mk(0, 10, 2, dl, 8'hFF, 1'b0, 1), -1, 1'b0, 1'b0, 1'b0, b_n, d_n, p_n, n_n, x_n);
        check("restart_pos_count", 0, p_n, 16);

        // start and stop together in IDLE: nothing happens.
        start = 1'b1; stop = 1'b1;
        @(negedge clock);
        start = 1'b0; stop = 1'b0;
        check("start_stop_idle", 0, {30'd0, busy, done}, 32'd0);

        // Asynchronous reset in the middle of a burst.
        apply_cfg(mk(0, 10, 5, fill_delay(0), 8'hFF, 1'b0, 1));
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_reset_pos", 3, {24'd0, pos_out}, 32'h0000_00FF);
        #1 reset_n = 1'b0;
        #1 check("async_reset_clear", 0, {14'd0, pos_out, neg_out, busy, done}, 32'd0);
        #1 reset_n = 1'b1;
        d_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            d_n += int'(done) + int'(busy) + $countones(pos_out);
        end
        check("post_reset_quiet", 0, d_n, 0);

        // Randomized bursts against the reference model.
        for (int r = 0; r < 24; r++) begin
            cfg_t rc;
            int sk, len;
            rc  = rand_cfg();
            len = run_len(rc);
            sk  = (len > 3 && $urandom_range(0, 3) == 0) ? int'($urandom_range(1, len - 1)) : -1;
            run_burst(rc, sk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1,
                      b_n, d_n, p_n, n_n, x_n);
            check("rnd_pos_neg_overlap", r, x_n, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
